mem_access_stage: RTL and testbench

- Memory stage between execute and writeback. Drives the data BRAM port, aligns store data, generates byte write enables, and decodes memory-mapped IO (UART, cycle/instruction counters).
- Registers the load side-band so the writeback-stage load extender receives the raw 32-bit word, byte offset and funct3 in the cycle the synchronous BRAM data returns.

---
 rtl/mem_access_stage.sv | 126 ++++++++++++
 tb/tb_mem_access_stage.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// Memory stage between execute and writeback. It drives the data BRAM, decodes the
// UART/counter IO window, and registers the load side-band for the writeback extender.
module mem_access_stage #(
    parameter int DMEM_AW        = 14,
    parameter int CPU_CLOCK_FREQ = 50000000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        ex_addr,
    input  logic [31:0]        ex_wdata,
    input  logic [2:0]         ex_funct3,
    input  logic               ex_mem_rd,
    input  logic               ex_mem_wr,
    input  logic               ex_inst_valid,
    output logic [DMEM_AW-1:0] dmem_addr,
    output logic [3:0]         dmem_we,
    output logic [31:0]        dmem_din,
    input  logic [31:0]        dmem_dout,
    input  logic [7:0]         uart_rx_data,
    input  logic               uart_rx_valid,
    output logic               uart_rx_ready,
    output logic [7:0]         uart_tx_data,
    output logic               uart_tx_valid,
    input  logic               uart_tx_ready,
    output logic [31:0]        wb_word,
    output logic [1:0]         wb_sel,
    output logic [2:0]         wb_ldsel
);
    typedef enum logic [1:0] {TAG_NONE, TAG_DMEM, TAG_IO} tag_t;

    localparam logic [5:0] OFF_STAT  = 6'h00;
    localparam logic [5:0] OFF_RX    = 6'h01;
    localparam logic [5:0] OFF_TX    = 6'h02;
    localparam logic [5:0] OFF_CYC   = 6'h04;
    localparam logic [5:0] OFF_INST  = 6'h05;
    localparam logic [5:0] OFF_CLR   = 6'h06;

    logic        is_dmem, is_io;
    logic [5:0]  io_off;
    logic [31:0] io_rdata, io_q;
    logic [31:0] cyc_cnt, inst_cnt;
    logic        cnt_clr;
    tag_t        tag, tag_q;

    // Clock frequency is informational only; the sink below keeps lint quiet about it.
    logic unused_bits;
    assign unused_bits = ^{ex_addr[27:DMEM_AW+2], (CPU_CLOCK_FREQ > 0)};

    assign is_dmem = (ex_addr[31:28] == 4'b0001) || (ex_addr[31:28] == 4'b0011);
    assign is_io   = (ex_addr[31:28] == 4'b1000) && (ex_addr[27:8] == 20'd0);
    assign io_off  = ex_addr[7:2];
    assign tag     = is_dmem ? TAG_DMEM : (is_io ? TAG_IO : TAG_NONE);

    assign dmem_addr = ex_addr[DMEM_AW+1:2];

    always_comb begin
        dmem_we  = 4'b0000;
        dmem_din = ex_wdata;
        unique case (ex_funct3[1:0])
            2'b00: begin
                dmem_we  = 4'b0001 << ex_addr[1:0];
                dmem_din = {4{ex_wdata[7:0]}};
            end
            2'b01: begin
                dmem_we  = ex_addr[1] ? 4'b1100 : 4'b0011;
                dmem_din = {2{ex_wdata[15:0]}};
            end
            2'b10: dmem_we = 4'b1111;
            default: dmem_we = 4'b0000;
        endcase
        if (rst || !ex_mem_wr || !is_dmem)
            dmem_we = 4'b0000;
    end

    always_comb begin
        io_rdata = 32'd0;
        if (is_io) begin
            case (io_off)
                OFF_STAT: io_rdata = {30'd0, uart_rx_valid, uart_tx_ready};
                OFF_RX:   io_rdata = {24'd0, uart_rx_data};
                OFF_CYC:  io_rdata = cyc_cnt;
                OFF_INST: io_rdata = inst_cnt;
                default:  io_rdata = 32'd0;
            endcase
        end
    end

    assign uart_rx_ready = !rst && is_io && ex_mem_rd && (io_off == OFF_RX);
    assign uart_tx_valid = !rst && is_io && ex_mem_wr && (io_off == OFF_TX) && uart_tx_ready;
    assign uart_tx_data  = ex_wdata[7:0];
    assign cnt_clr       = is_io && ex_mem_wr && (io_off == OFF_CLR);

    // Clear beats increment, including a retire in the same cycle.
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            cyc_cnt  <= 32'd0;
            inst_cnt <= 32'd0;
        end else begin
            cyc_cnt  <= cyc_cnt + 32'd1;
            inst_cnt <= inst_cnt + {31'd0, ex_inst_valid};
        end
    end

    // Side-band lines up with the BRAM's one-cycle read latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_sel   <= 2'd0;
            wb_ldsel <= 3'd0;
            tag_q    <= TAG_NONE;
            io_q     <= 32'd0;
        end else begin
            wb_sel   <= ex_addr[1:0];
            wb_ldsel <= ex_funct3;
            tag_q    <= tag;
            io_q     <= io_rdata;
        end
    end

    always_comb begin
        case (tag_q)
            TAG_DMEM: wb_word = dmem_dout;
            TAG_IO:   wb_word = io_q;
            default:  wb_word = 32'd0;
        endcase
    end
endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage; a small synchronous BRAM model sits on the dmem port.
module tb_mem_access_stage;
    localparam int AW = 14;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   ex_addr, ex_wdata;
    logic [2:0]    ex_funct3;
    logic          ex_mem_rd, ex_mem_wr, ex_inst_valid;
    logic [AW-1:0] dmem_addr;
    logic [3:0]    dmem_we;
    logic [31:0]   dmem_din, dmem_dout;
    logic [7:0]    uart_rx_data, uart_tx_data;
    logic          uart_rx_valid, uart_rx_ready, uart_tx_valid, uart_tx_ready;
    logic [31:0]   wb_word;
    logic [1:0]    wb_sel;
    logic [2:0]    wb_ldsel;

    int checks = 0;
    int errors = 0;

    mem_access_stage #(.DMEM_AW(AW), .CPU_CLOCK_FREQ(50000000)) dut (
        .clk(clk), .rst(rst), .ex_addr(ex_addr), .ex_wdata(ex_wdata),
        .ex_funct3(ex_funct3), .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr),
        .ex_inst_valid(ex_inst_valid), .dmem_addr(dmem_addr), .dmem_we(dmem_we),
        .dmem_din(dmem_din), .dmem_dout(dmem_dout), .uart_rx_data(uart_rx_data),
        .uart_rx_valid(uart_rx_valid), .uart_rx_ready(uart_rx_ready),
        .uart_tx_data(uart_tx_data), .uart_tx_valid(uart_tx_valid),
        .uart_tx_ready(uart_tx_ready), .wb_word(wb_word), .wb_sel(wb_sel),
        .wb_ldsel(wb_ldsel)
    );

    always #5 clk = ~clk;

    // Read-first synchronous BRAM with byte enables.
    logic [31:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++)
            if (dmem_we[b]) mem[dmem_addr][b*8 +: 8] <= dmem_din[b*8 +: 8];
        dmem_dout <= mem[dmem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3,
                         input logic rd, input logic wr);
        ex_addr = a; ex_wdata = d; ex_funct3 = f3; ex_mem_rd = rd; ex_mem_wr = wr;
    endtask

    task automatic idle();
        drive(32'h0, 32'h0, 3'b000, 1'b0, 1'b0);
    endtask

    // Inputs change right after a negedge; the following negedge sees the posedge result.
    task automatic nxt();
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < (1<<AW); i++) mem[i] = 32'h0;
        rst = 1'b1; ex_inst_valid = 1'b0;
        uart_rx_data = 8'h00; uart_rx_valid = 1'b0; uart_tx_ready = 1'b0;
        drive(32'h1000_0000, 32'hFFFF_FFFF, 3'b010, 1'b1, 1'b1);
        nxt(); nxt();
        #1;
        chk("rst_we", {28'd0, dmem_we}, 32'h0);
        chk("rst_word", wb_word, 32'h0);
        chk("rst_sel", {29'd0, wb_ldsel}, 32'h0);

        // Release reset and count 100 cycles, 40 of them retiring.
        idle();
        rst = 1'b0;
        for (int i = 0; i < 100; i++) begin
            ex_inst_valid = (i < 40);
            nxt();
        end
        ex_inst_valid = 1'b0;
        drive(32'h8000_0010, 32'h0, 3'b010, 1'b1, 1'b0);
        nxt();
        chk("cyc_cnt", wb_word, 32'd100);
        drive(32'h8000_0014, 32'h0, 3'b010, 1'b1, 1'b0);
        nxt();
        chk("inst_cnt", wb_word, 32'd40);

        // Clear wins over a retire in the same cycle.
        ex_inst_valid = 1'b1;
        drive(32'h8000_0018, 32'hDEAD_BEEF, 3'b010, 1'b0, 1'b1);
        nxt();
        drive(32'h8000_0010, 32'h0, 3'b010, 1'b1, 1'b0);
        nxt();
        chk("cyc_clr", wb_word, 32'd0);
        drive(32'h8000_0018, 32'h0, 3'b010, 1'b0, 1'b1);
        nxt();
        drive(32'h8000_0014, 32'h0, 3'b010, 1'b1, 1'b0);
        nxt();
        chk("inst_clr", wb_word, 32'd0);
        ex_inst_valid = 1'b0;

        // Byte and half stores.
        drive(32'h1000_0006, 32'hAABB_CCDD, 3'b000, 1'b0, 1'b1);
        #1;
        chk("sb_we", {28'd0, dmem_we}, 32'h4);
        chk("sb_din", dmem_din, 32'hDDDD_DDDD);
        chk("sb_addr", {18'd0, dmem_addr}, 32'd1);
        drive(32'h1000_0002, 32'hAABB_CCDD, 3'b001, 1'b0, 1'b1);
        #1;
        chk("sh_we", {28'd0, dmem_we}, 32'hC);
        chk("sh_din", dmem_din, 32'hCCDD_CCDD);
        drive(32'h1000_0001, 32'hAABB_CCDD, 3'b001, 1'b0, 1'b1);
        #1;
        chk("sh_lo_we", {28'd0, dmem_we}, 32'h3);

        // SW then LB at +3 returns the raw word and side-band.
        nxt();
        drive(32'h1000_0010, 32'h1234_5678, 3'b010, 1'b0, 1'b1);
        #1;
        chk("sw_we", {28'd0, dmem_we}, 32'hF);
        nxt();
        drive(32'h1000_0013, 32'h0, 3'b000, 1'b1, 1'b0);
        nxt();
        chk("lb_word", wb_word, 32'h1234_5678);
        chk("lb_sel", {30'd0, wb_sel}, 32'd3);
        chk("lb_ldsel", {29'd0, wb_ldsel}, 32'd0);

        // UART transmit with and without ready.
        uart_tx_ready = 1'b1;
        drive(32'h8000_0008, 32'h0000_0041, 3'b010, 1'b0, 1'b1);
        #1;
        chk("tx_valid", {31'd0, uart_tx_valid}, 32'd1);
        chk("tx_data", {24'd0, uart_tx_data}, 32'h41);
        nxt();
        idle();
        #1;
        chk("tx_one_cycle", {31'd0, uart_tx_valid}, 32'd0);
        uart_tx_ready = 1'b0;
        drive(32'h8000_0008, 32'h0000_0041, 3'b010, 1'b0, 1'b1);
        #1;
        chk("tx_blocked", {31'd0, uart_tx_valid}, 32'd0);
        nxt();

        // UART status and receive.
        uart_tx_ready = 1'b1; uart_rx_valid = 1'b1; uart_rx_data = 8'h5A;
        drive(32'h8000_0000, 32'h0, 3'b010, 1'b1, 1'b0);
        #1;
        chk("stat_no_rxrdy", {31'd0, uart_rx_ready}, 32'd0);
        nxt();
        chk("stat_word", wb_word, 32'h3);
        drive(32'h8000_0004, 32'h0, 3'b010, 1'b1, 1'b0);
        #1;
        chk("rx_ready", {31'd0, uart_rx_ready}, 32'd1);
        nxt();
        chk("rx_word", wb_word, 32'h5A);
        drive(32'h8000_0020, 32'h0, 3'b010, 1'b1, 1'b0);
        #1;
        chk("rx_ready_drop", {31'd0, uart_rx_ready}, 32'd0);
        nxt();
        chk("io_other", wb_word, 32'h0);

        // Reset mid-operation: pending IO load, then a store under reset.
        drive(32'h8000_0003, 32'h0, 3'b100, 1'b1, 1'b0);
        nxt();
        rst = 1'b1;
        drive(32'h1000_0003, 32'h5555_5555, 3'b001, 1'b0, 1'b1);
        #1;
        chk("rst_store_we", {28'd0, dmem_we}, 32'h0);
        nxt();
        rst = 1'b0;
        idle();
        chk("rst_wb_word", wb_word, 32'h0);
        chk("rst_wb_sel", {30'd0, wb_sel}, 32'd0);
        chk("rst_wb_ldsel", {29'd0, wb_ldsel}, 32'd0);

        // Unmapped region: store dropped, load returns 0.
        drive(32'h4000_0000, 32'hFFFF_FFFF, 3'b010, 1'b0, 1'b1);
        #1;
        chk("unmap_we", {28'd0, dmem_we}, 32'h0);
        chk("unmap_tx", {31'd0, uart_tx_valid}, 32'd0);
        nxt();
        drive(32'h4000_0000, 32'h0, 3'b010, 1'b1, 1'b0);
        nxt();
        chk("unmap_load", wb_word, 32'h0);
        idle();
        nxt();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
